// File: rtl/lsu_riscv_if.sv
// lsu_riscv_if: core-side and data-memory-side signals of the load-store unit.
//   slave  : LSU view (core request + memory response in, formatted data/memory request out)
//   master : environment view (core + memory model driving the LSU)
interface lsu_riscv_if;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        misaligned_o;
  logic        fault_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  modport slave (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    input  mem_rd_i, mem_ready_i,
    output core_rd_o, core_stall_o, misaligned_o, fault_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );

  modport master (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    output mem_rd_i, mem_ready_i,
    input  core_rd_o, core_stall_o, misaligned_o, fault_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );
endinterface

// File: rtl/lsu_riscv.sv
// lsu_riscv: load-store unit between the core datapath and the data-memory port.
//   clk_i, rst_i : core clock, synchronous active-high reset
//   bus          : lsu_riscv_if.slave
//     core_*     : request (req/we/size/addr/wd) in; formatted load data, stall out
//     misaligned_o / fault_o : one-cycle misaligned-access / timeout flags
//     mem_*      : memory request, byte enables, lane-replicated write data; read data + ready in
// IDLE drives the memory port straight from the core inputs; BUSY replays the
// latched request until mem_ready_i or the timeout counter expires.
module lsu_riscv #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic       clk_i,
  input logic       rst_i,
  lsu_riscv_if.slave bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  function automatic logic is_byte(input logic [2:0] size);
    return (size == LDST_B) || (size == LDST_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] size);
    return (size == LDST_H) || (size == LDST_HU);
  endfunction

  // Unlisted size codes fall through to word behaviour everywhere.
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] off);
    if (is_half(size)) return off[0];
    if (is_byte(size)) return 1'b0;
    return off != 2'd0;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
    if (is_byte(size)) return 4'b0001 << off;
    if (is_half(size)) return off[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] wr_data(input logic [2:0] size, input logic [31:0] wd);
    if (is_byte(size)) return {4{wd[7:0]}};
    if (is_half(size)) return {2{wd[15:0]}};
    return wd;
  endfunction

  function automatic logic [31:0] rd_data(input logic [2:0] size, input logic [1:0] off,
                                          input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[{off, 3'b000} +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (size)
      LDST_B:  r = {{24{b[7]}}, b};
      LDST_BU: r = {24'd0, b};
      LDST_H:  r = {{16{h[15]}}, h};
      LDST_HU: r = {16'd0, h};
      LDST_W:  r = rd;
      default: r = rd;
    endcase
    return r;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      lat_addr_q, lat_wd_q;
  logic             lat_we_q;
  logic [2:0]       lat_size_q;
  logic             accept;

  logic [31:0] rd_c, addr_c, wd_c;
  logic [3:0]  be_c;
  logic        stall_c, mis_c, fault_c, req_c, we_c;

  // State, timeout counter and latched request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lat_addr_q <= '0;
      lat_wd_q   <= '0;
      lat_we_q   <= 1'b0;
      lat_size_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        lat_addr_q <= bus.core_addr_i;
        lat_wd_q   <= bus.core_wd_i;
        lat_we_q   <= bus.core_we_i;
        lat_size_q <= bus.core_size_i;
      end
    end
  end

  // Next state and outputs; everything stays 0 while reset is held.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    rd_c    = '0;
    stall_c = 1'b0;
    mis_c   = 1'b0;
    fault_c = 1'b0;
    req_c   = 1'b0;
    we_c    = 1'b0;
    be_c    = '0;
    addr_c  = '0;
    wd_c    = '0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (bus.core_req_i) begin
            if (misaligned(bus.core_size_i, bus.core_addr_i[1:0])) begin
              mis_c = 1'b1;
            end else begin
              accept  = 1'b1;
              req_c   = 1'b1;
              stall_c = 1'b1;
              we_c    = bus.core_we_i;
              addr_c  = bus.core_addr_i;
              be_c    = byte_en(bus.core_size_i, bus.core_addr_i[1:0]);
              wd_c    = wr_data(bus.core_size_i, bus.core_wd_i);
              cnt_d   = '0;
              state_d = BUSY;
            end
          end
        end
        default: begin
          req_c  = 1'b1;
          we_c   = lat_we_q;
          addr_c = lat_addr_q;
          be_c   = byte_en(lat_size_q, lat_addr_q[1:0]);
          wd_c   = wr_data(lat_size_q, lat_wd_q);
          cnt_d  = cnt_q + CNT_W'(1);
          // A ready arriving in the last allowed cycle beats the timeout.
          if (bus.mem_ready_i) begin
            state_d = IDLE;
            if (!lat_we_q) rd_c = rd_data(lat_size_q, lat_addr_q[1:0], bus.mem_rd_i);
          end else if (TMO_EN && (cnt_q == CNT_LAST)) begin
            fault_c = 1'b1;
            req_c   = 1'b0;
            state_d = IDLE;
          end else begin
            stall_c = 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.core_rd_o    = rd_c;
  assign bus.core_stall_o = stall_c;
  assign bus.misaligned_o = mis_c;
  assign bus.fault_o      = fault_c;
  assign bus.mem_req_o    = req_c;
  assign bus.mem_we_o     = we_c;
  assign bus.mem_be_o     = be_c;
  assign bus.mem_addr_o   = addr_c;
  assign bus.mem_wd_o     = wd_c;

endmodule

// File: tb/tb_lsu_riscv.sv
// tb_lsu_riscv: directed literal checks plus a randomized run of lsu_riscv,
// every cycle compared against a transaction-level model of the unit.
module tb_lsu_riscv;
  localparam int unsigned TMO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_riscv_if bus();

  lsu_riscv #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: access width in bytes, natural lane position.
  function automatic int nbytes(input logic [2:0] s);
    if (s == 3'd0 || s == 3'd4) return 1;
    if (s == 3'd1 || s == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(input logic [2:0] s, input logic [31:0] a);
    return (int'(a[1:0]) % nbytes(s)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] s, input logic [31:0] a);
    int n, start;
    n = nbytes(s);
    if (n == 4) return 4'hF;
    start = (int'(a[1:0]) / n) * n;
    return 4'(((1 << n) - 1) << start);
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] s, input logic [31:0] wd);
    int n;
    n = nbytes(s);
    if (n == 1) return (wd & 32'hFF) * 32'h01010101;
    if (n == 2) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] s, input logic [31:0] a,
                                       input logic [31:0] rd);
    int n, start;
    logic [31:0] mask, v;
    n = nbytes(s);
    if (n == 4) return rd;
    start = (int'(a[1:0]) / n) * n;
    mask  = (32'd1 << (8 * n)) - 32'd1;
    v     = (rd >> (8 * start)) & mask;
    if (s < 3'd4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  bit          busy = 1'b0;
  logic [31:0] p_addr = '0, p_wd = '0;
  logic        p_we = 1'b0;
  logic [2:0]  p_size = '0;
  int          waited = 0;

  logic [31:0] e_rd, e_addr, e_wd;
  logic [3:0]  e_be;
  logic        e_stall, e_mis, e_fault, e_req, e_we;

  // Per-cycle compare against the model, then advance the model to the next cycle.
  always @(negedge clk) begin
    e_rd = '0; e_addr = '0; e_wd = '0; e_be = '0;
    e_stall = 1'b0; e_mis = 1'b0; e_fault = 1'b0; e_req = 1'b0; e_we = 1'b0;
    if (rst) begin
      busy = 1'b0;
    end else if (!busy) begin
      if (bus.core_req_i) begin
        if (m_mis(bus.core_size_i, bus.core_addr_i)) begin
          e_mis = 1'b1;
        end else begin
          e_req = 1'b1; e_stall = 1'b1; e_we = bus.core_we_i;
          e_addr = bus.core_addr_i;
          e_be = m_be(bus.core_size_i, bus.core_addr_i);
          e_wd = m_wd(bus.core_size_i, bus.core_wd_i);
          p_addr = bus.core_addr_i; p_wd = bus.core_wd_i;
          p_we = bus.core_we_i; p_size = bus.core_size_i;
          busy = 1'b1; waited = 0;
        end
      end
    end else begin
      e_req = 1'b1; e_we = p_we; e_addr = p_addr;
      e_be = m_be(p_size, p_addr); e_wd = m_wd(p_size, p_wd);
      if (bus.mem_ready_i) begin
        e_rd = p_we ? 32'd0 : m_rd(p_size, p_addr, bus.mem_rd_i);
        busy = 1'b0;
      end else if (TMO != 0 && waited + 1 == int'(TMO)) begin
        e_fault = 1'b1; e_req = 1'b0; busy = 1'b0;
      end else begin
        e_stall = 1'b1; waited++;
      end
    end
    chk("m_rd",    bus.core_rd_o,    e_rd);
    chk("m_stall", bus.core_stall_o, e_stall);
    chk("m_mis",   bus.misaligned_o, e_mis);
    chk("m_fault", bus.fault_o,      e_fault);
    chk("m_req",   bus.mem_req_o,    e_req);
    chk("m_we",    bus.mem_we_o,     e_we);
    chk("m_be",    bus.mem_be_o,     e_be);
    chk("m_addr",  bus.mem_addr_o,   e_addr);
    chk("m_wd",    bus.mem_wd_o,     e_wd);
  end

  task automatic drive(input logic req, input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic ready, input logic [31:0] rd);
    @(posedge clk);
    #1;
    bus.core_req_i  = req;
    bus.core_we_i   = we;
    bus.core_size_i = size;
    bus.core_addr_i = addr;
    bus.core_wd_i   = wd;
    bus.mem_ready_i = ready;
    bus.mem_rd_i    = rd;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.core_req_i = 1'b0; bus.core_we_i = 1'b0; bus.core_size_i = '0;
    bus.core_addr_i = '0; bus.core_wd_i = '0; bus.mem_ready_i = 1'b0; bus.mem_rd_i = '0;
    settle();
    chk("rst_req", bus.mem_req_o, 0);
    chk("rst_stall", bus.core_stall_o, 0);
    chk("rst_rd", bus.core_rd_o, 0);
    drive(0, 0, 3'd0, 0, 0, 0, 0);
    rst = 1'b0;

    // SW, ready on the third BUSY cycle
    drive(1, 1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0); settle();
    chk("sw_be0", bus.mem_be_o, 4'hF); chk("sw_wd0", bus.mem_wd_o, 32'hDEADBEEF);
    chk("sw_stall0", bus.core_stall_o, 1);
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 3'd0, 0, 0, (i == 3), 0); settle();
      chk("sw_be", bus.mem_be_o, 4'hF); chk("sw_wd", bus.mem_wd_o, 32'hDEADBEEF);
      chk("sw_stall", bus.core_stall_o, (i == 3) ? 0 : 1);
    end

    // LB / LBU / LHU with immediate ready
    drive(1, 0, 3'd0, 32'h203, 0, 0, 0); settle();
    chk("lb_be", bus.mem_be_o, 4'b1000);
    drive(0, 0, 3'd0, 0, 0, 1, 32'h80112233); settle();
    chk("lb_rd", bus.core_rd_o, 32'hFFFFFF80); chk("lb_stall", bus.core_stall_o, 0);
    drive(1, 0, 3'd4, 32'h203, 0, 0, 0); settle();
    drive(0, 0, 3'd0, 0, 0, 1, 32'h80112233); settle();
    chk("lbu_rd", bus.core_rd_o, 32'h00000080);
    drive(1, 0, 3'd5, 32'h202, 0, 0, 0); settle();
    chk("lhu_be", bus.mem_be_o, 4'b1100);
    drive(0, 0, 3'd0, 0, 0, 1, 32'h80112233); settle();
    chk("lhu_rd", bus.core_rd_o, 32'h00008011);

    // SB / SH lane replication
    drive(1, 1, 3'd0, 32'h1, 32'h000000AB, 0, 0); settle();
    chk("sb_be", bus.mem_be_o, 4'b0010); chk("sb_wd", bus.mem_wd_o, 32'hABABABAB);
    drive(0, 0, 3'd0, 0, 0, 1, 32'h55555555); settle();
    chk("sb_rd", bus.core_rd_o, 0);
    drive(1, 1, 3'd1, 32'h2, 32'h00001234, 0, 0); settle();
    chk("sh_be", bus.mem_be_o, 4'b1100); chk("sh_wd", bus.mem_wd_o, 32'h12341234);
    drive(0, 0, 3'd0, 0, 0, 1, 0); settle();

    // Misaligned LW / LH
    drive(1, 0, 3'd2, 32'h102, 0, 0, 0); settle();
    chk("lw_mis", bus.misaligned_o, 1); chk("lw_mis_req", bus.mem_req_o, 0);
    chk("lw_mis_stall", bus.core_stall_o, 0);
    drive(1, 0, 3'd1, 32'h101, 0, 0, 0); settle();
    chk("lh_mis", bus.misaligned_o, 1); chk("lh_mis_req", bus.mem_req_o, 0);
    drive(0, 0, 3'd0, 0, 0, 0, 0); settle();
    chk("mis_clear", bus.misaligned_o, 0);

    // Timeout after TMO BUSY cycles, then ready winning in that same cycle
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 3'd2, 32'h40, 0, 0, 0); settle();
      for (int i = 1; i <= 4; i++) begin
        drive(0, 0, 3'd0, 0, 0, (k == 1 && i == 4), 32'h0BADF00D); settle();
        if (i < 4) chk("tmo_stall", bus.core_stall_o, 1);
      end
      chk("tmo_fault", bus.fault_o, (k == 0) ? 1 : 0);
      chk("tmo_stall4", bus.core_stall_o, 0);
      chk("tmo_req4", bus.mem_req_o, (k == 0) ? 0 : 1);
      drive(0, 0, 3'd0, 0, 0, 0, 0); settle();
      chk("tmo_idle", bus.mem_req_o, 0); chk("tmo_fault_clr", bus.fault_o, 0);
    end

    // Reset in the middle of an access
    drive(1, 0, 3'd2, 32'h80, 0, 0, 0); settle();
    drive(0, 0, 3'd0, 0, 0, 0, 0); rst = 1'b1; settle();
    chk("rstb_req", bus.mem_req_o, 0); chk("rstb_stall", bus.core_stall_o, 0);
    drive(0, 0, 3'd0, 0, 0, 1, 32'h12345678); rst = 1'b0; settle();
    chk("rstb_after_req", bus.mem_req_o, 0); chk("rstb_after_rd", bus.core_rd_o, 0);
    chk("rstb_after_fault", bus.fault_o, 0);
    drive(1, 0, 3'd2, 32'h84, 0, 0, 0); settle();
    chk("post_rst_req", bus.mem_req_o, 1);
    drive(0, 0, 3'd0, 0, 0, 1, 32'hA5A5A5A5); settle();
    chk("post_rst_rd", bus.core_rd_o, 32'hA5A5A5A5);

    // Back-to-back LW then SW, two cycles each
    drive(1, 0, 3'd2, 32'h10, 0, 0, 0); settle();
    chk("b2b_lw_stall", bus.core_stall_o, 1);
    drive(1, 1, 3'd2, 32'h14, 32'hCAFEF00D, 1, 32'h11223344); settle();
    chk("b2b_lw_rd", bus.core_rd_o, 32'h11223344); chk("b2b_lw_done", bus.core_stall_o, 0);
    drive(1, 1, 3'd2, 32'h14, 32'hCAFEF00D, 0, 0); settle();
    chk("b2b_sw_we", bus.mem_we_o, 1); chk("b2b_sw_wd", bus.mem_wd_o, 32'hCAFEF00D);
    chk("b2b_sw_stall", bus.core_stall_o, 1);
    drive(0, 0, 3'd0, 0, 0, 1, 0); settle();
    chk("b2b_sw_done", bus.core_stall_o, 0);

    // Randomized traffic; the model process checks every cycle
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      rst             = ($urandom_range(0, 63) == 0);
      bus.core_req_i  = ($urandom_range(0, 2) != 0);
      bus.core_we_i   = 1'($urandom_range(0, 1));
      bus.core_size_i = 3'($urandom_range(0, 7));
      bus.core_addr_i = $urandom;
      bus.core_wd_i   = $urandom;
      bus.mem_ready_i = ($urandom_range(0, 2) == 0);
      bus.mem_rd_i    = $urandom;
    end

    drive(0, 0, 3'd0, 0, 0, 0, 0);
    rst = 1'b1;
    settle();
    settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu_riscv.md
Name: lsu_riscv

Overview:
- Load-store unit that executes the memory request the main decoder issues (req / we / size) against the external data memory.
- Generates byte enables and lane-replicated write data, formats and sign- or zero-extends read data, and stalls the core until the memory answers.
- Flags misaligned accesses and memory timeouts.
- Sits between the core datapath (ALU result as address, RS2 as store data, writeback mux for load data) and the data-memory port.

Parameters:
- TIMEOUT_CYCLES, 255, number of BUSY cycles without mem_ready_i before an access fault; 0 disables the timeout.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous active-high reset
- core_req_i  in  1  memory request from decoder (mem_req_o)
- core_we_i  in  1  1 = store, 0 = load
- core_size_i  in  3  LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5
- core_addr_i  in  32  byte address (ALU result)
- core_wd_i  in  32  store data (RS2)
- core_rd_o  out  32  formatted load data for writeback
- core_stall_o  out  1  stall core / PC
- misaligned_o  out  1  one-cycle misaligned-access flag
- fault_o  out  1  one-cycle access-timeout flag
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  memory address
- mem_wd_o  out  32  memory write data
- mem_rd_i  in  32  memory read data
- mem_ready_i  in  1  memory response / ack

Behaviour:
- Clock and reset are fixed: one clock, clk_i. rst_i is synchronous and active-high.
- While rst_i=1, all outputs are 0, the FSM goes to IDLE and the timeout counter is cleared.
- Reset asserted mid-access aborts the access: mem_req_o drops in the reset cycle, and no fault or misaligned flag is raised.

FSM states are IDLE and BUSY.

IDLE:
- Outputs are driven combinationally from the core inputs.
- Misaligned condition: H/HU with addr[0]=1, or W with addr[1:0]≠0.
- core_req_i=1 and misaligned: mem_req_o=0, core_stall_o=0, misaligned_o=1 for this cycle; stay in IDLE.
- core_req_i=1 and aligned:
  - mem_req_o=1, core_stall_o=1.
  - Latch addr, we, size and wd into registers.
  - Clear the counter and go to BUSY.
- core_req_i=0: mem_req_o=0, core_stall_o=0. mem_ready_i is ignored.

BUSY:
- mem_req_o=1. mem_we_o, mem_addr_o, mem_be_o and mem_wd_o come from the latched registers.
- The counter increments each cycle.
- mem_ready_i=1:
  - core_stall_o=0 in the same cycle.
  - For loads, core_rd_o is driven combinationally from mem_rd_i during this cycle.
  - Next state is IDLE, so a back-to-back request is accepted on the following cycle.
- mem_ready_i=0: core_stall_o=1.
- Timeout: counter == TIMEOUT_CYCLES-1 and mem_ready_i=0 (TIMEOUT_CYCLES≠0):
  - fault_o=1, core_stall_o=0, mem_req_o=0 for this cycle; go to IDLE.
  - mem_ready_i in the same cycle wins: no fault.
- Minimum load/store latency is 2 cycles: the request cycle plus the ready cycle.

Byte enables (off = addr[1:0]):
- B/BU: 4'b0001 << off.
- H/HU: off[1] ? 4'b1100 : 4'b0011.
- W: 4'b1111.
- Size codes 3, 6 and 7 are handled as W.

Write data:
- B: byte wd[7:0] replicated ×4.
- H: halfword wd[15:0] replicated ×2.
- W: wd passed through unchanged.

Read data:
- B: sign-extended byte at lane off.
- BU: zero-extended byte at lane off.
- H: sign-extended half at lane off[1].
- HU: zero-extended half at lane off[1].
- W: mem_rd_i unchanged.
- core_rd_o=0 for stores and whenever no valid load completes.

Test Plan:
- SW addr=0x100, wd=0xDEADBEEF, ready on 3rd BUSY cycle -> mem_be_o=4'hF and mem_wd_o=0xDEADBEEF held 4 cycles; core_stall_o=1 for 3 cycles, then 0 in the ready cycle.
- LB addr=0x203, mem_rd_i=0x80112233, immediate ready -> mem_be_o=4'b1000, core_rd_o=0xFFFFFF80. LBU same -> 0x00000080. LHU addr=0x202 -> be=4'b1100, rd=0x00008011.
- SB addr=0x1, wd=0x000000AB -> be=4'b0010, wd=0xABABABAB. SH addr=0x2, wd=0x1234 -> be=4'b1100, wd=0x12341234.
- LW addr=0x102 -> misaligned_o=1 for one cycle, mem_req_o=0, no stall. LH addr=0x101 -> same.
- TIMEOUT_CYCLES=4, mem_ready_i held 0 -> fault_o=1 in the 4th BUSY cycle, stall released, mem_req_o=0, state IDLE. Ready in that same cycle -> no fault.
- rst_i pulsed during BUSY -> all outputs 0 next cycle. A new request after reset completes normally; back-to-back LW/SW complete in 2 cycles each.
